alu_share_scheduler: RTL and testbench

//  Shares one combinational 32-bit ALU (3-bit command: ADD=0,SUB=1,XOR=2,SLT=3,AND=4,NAND=5,OR=6,NOR=7)

---
 rtl/alu_share_scheduler_pkg.sv | 19 +
 rtl/alu_share_scheduler_if.sv | 31 +++
 rtl/alu_share_scheduler_rr_arbiter.sv | 34 +++
 rtl/alu_share_scheduler.sv | 130 +++++++++++++
 tb/tb_alu_share_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_scheduler_pkg.sv
// Shared definitions for the ALU share scheduler: ALU command codes and FSM state encoding.
package alu_sched_pkg;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_OR   = 3'd6;
  localparam logic [2:0] CMD_NOR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } schedState_t;

endpackage

// File: rtl/alu_share_scheduler_if.sv
// Request/response bundle between datapath clients (master) and the ALU share scheduler (slave).
interface alu_share_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_cmd;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IDW-1:0]           resp_id;
  logic [WIDTH-1:0]         resp_result;
  logic                     resp_carryout;
  logic                     resp_overflow;
  logic                     resp_zero;

  modport master (
    output req_valid, req_cmd, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result,
           resp_carryout, resp_overflow, resp_zero
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result,
           resp_carryout, resp_overflow, resp_zero
  );
endinterface

// File: rtl/alu_share_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rrPtr, wrapping cyclically.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rrPtr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grantIdx,
  output logic               anyReq
);

  int   idx;
  logic found;
  logic hit;

  // Scan from rrPtr; only the first hit is allowed to set a grant bit
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    hit      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx        = (int'(rrPtr) + k) % NUM_REQ;
      hit        = !found && req[idx];
      grant[idx] = grant[idx] | hit;
      grantIdx   = hit ? IDW'(idx) : grantIdx;
      found      = found | hit;
    end
    anyReq = found;
  end

endmodule

// File: rtl/alu_share_scheduler.sv
// Time-shares one combinational ALU between NUM_REQ clients: round-robin grant, operand hold for
// SETTLE_CYCLES clocks, then result/flag capture returned on a single response channel.
module alu_share_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int IDW           = 2
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_scheduler_if.slave bus,
  output logic [2:0]         alu_cmd,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  schedState_t         state;
  schedState_t         nextState;
  logic [IDW-1:0]      rrPtr;
  logic [CW-1:0]       cnt;
  logic [NUM_REQ-1:0]  grant;
  logic [IDW-1:0]      grantIdx;
  logic                anyReq;
  int                  gSel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) uArb (
    .req      (bus.req_valid),
    .rrPtr    (rrPtr),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyReq   (anyReq)
  );

  assign gSel = int'(grantIdx);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode; req_ready is only ever a same-cycle strobe out of IDLE
  always_comb begin
    nextState      = state;
    bus.req_ready  = '0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          nextState     = SETTLE;
          bus.req_ready = grant;
        end else begin
          nextState = IDLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          nextState = RESP;
        end else begin
          nextState = SETTLE;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          nextState = IDLE;
        end else begin
          nextState = RESP;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand launch on accept, settle countdown, and result capture at the end of settle
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr             <= '0;
      cnt               <= '0;
      alu_cmd           <= CMD_ADD;
      alu_a             <= '0;
      alu_b             <= '0;
      bus.resp_id       <= '0;
      bus.resp_result   <= '0;
      bus.resp_carryout <= 1'b0;
      bus.resp_overflow <= 1'b0;
      bus.resp_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            alu_cmd     <= bus.req_cmd[3*gSel +: 3];
            alu_a       <= bus.req_a[WIDTH*gSel +: WIDTH];
            alu_b       <= bus.req_b[WIDTH*gSel +: WIDTH];
            bus.resp_id <= grantIdx;
            rrPtr       <= (grantIdx == IDW'(NUM_REQ-1)) ? '0 : grantIdx + IDW'(1);
            cnt         <= CW'(SETTLE_CYCLES-1);
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            bus.resp_result   <= alu_out;
            bus.resp_carryout <= alu_carryout;
            bus.resp_overflow <= alu_overflow;
            bus.resp_zero     <= alu_zero;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Directed bench for alu_share_scheduler with a behavioural ALU and a transaction-level reference model.
module tb_alu_share_scheduler;
  import alu_sched_pkg::*;

  localparam int N      = 4;
  localparam int W      = 32;
  localparam int SETTLE = 4;

  logic         clk;
  logic         reset;
  logic [2:0]   aluCmd;
  logic [W-1:0] aluA, aluB, aluOut;
  logic         aluC, aluO, aluZ;
  int           cyc = 0;
  int           nVec = 0;
  int           nErr = 0;

  alu_share_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .IDW(2)) bus ();

  alu_share_scheduler #(.NUM_REQ(N), .WIDTH(W), .SETTLE_CYCLES(SETTLE), .IDW(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_cmd(aluCmd), .alu_a(aluA), .alu_b(aluB),
    .alu_out(aluOut), .alu_carryout(aluC), .alu_overflow(aluO), .alu_zero(aluZ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {carry, overflow, zero, result}
  function automatic logic [34:0] aluRef(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic co, ov;
    s = 33'd0; r = 32'd0; co = 1'b0; ov = 1'b0;
    case (c)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                  ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
                  ov = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = a | b;
      default: r = ~(a | b);
    endcase
    return {co, ov, (r == 32'd0), r};
  endfunction

  always_comb {aluC, aluO, aluZ, aluOut} = aluRef(aluCmd, aluA, aluB);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-robin choice as stated: first valid index at or after ptr, cyclic
  function automatic logic [N-1:0] rrPick(input logic [N-1:0] v, input int ptr, output int g);
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  // Reference model state
  bit          mBusy = 0;
  bit          mAfterReset = 1;
  int          mRr = 0;
  int          mDue, mId;
  logic [2:0]  mCmd;
  logic [31:0] mA, mB;
  logic [34:0] mExp;

  // Compare process: every cycle, outputs are checked against the transaction model
  always @(negedge clk) begin
    int g;
    logic [N-1:0] expReady;
    if (reset) begin
      mBusy = 0; mRr = 0; mAfterReset = 1;
    end else begin
      if (mAfterReset) begin
        check("rst alu_cmd", aluCmd, 0);
        check("rst alu_a", aluA, 0);
        check("rst alu_b", aluB, 0);
        check("rst resp", {bus.resp_id, bus.resp_carryout, bus.resp_overflow, bus.resp_zero, bus.resp_result}, 0);
        mAfterReset = 0;
      end
      if (!mBusy) begin
        expReady = rrPick(bus.req_valid, mRr, g);
        check("req_ready", bus.req_ready, expReady);
        check("resp_valid idle", bus.resp_valid, 0);
        if (g >= 0) begin
          mBusy = 1; mDue = cyc + SETTLE + 1; mId = g;
          mCmd = bus.req_cmd[3*g +: 3]; mA = bus.req_a[W*g +: W]; mB = bus.req_b[W*g +: W];
          mExp = aluRef(mCmd, mA, mB);
          mRr = (g + 1) % N;
        end
      end else begin
        check("req_ready busy", bus.req_ready, 0);
        check("alu_cmd hold", aluCmd, mCmd);
        check("alu_a hold", aluA, mA);
        check("alu_b hold", aluB, mB);
        if (cyc < mDue) begin
          check("resp_valid early", bus.resp_valid, 0);
        end else begin
          check("resp_valid", bus.resp_valid, 1);
          check("resp_id", bus.resp_id, mId);
          check("resp data", {bus.resp_carryout, bus.resp_overflow, bus.resp_zero, bus.resp_result}, mExp);
          if (bus.resp_ready) mBusy = 0;
        end
      end
    end
  end

  task automatic setReq(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_cmd[3*i +: 3] = c;
    bus.req_a[W*i +: W] = a;
    bus.req_b[W*i +: W] = b;
  endtask

  task automatic waitAccept(input int i, output int acc);
    bit got = 0;
    acc = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.req_valid[i] && bus.req_ready[i]) begin got = 1; acc = cyc; end
    end
    check("accept timeout", got, 1);
  endtask

  task automatic waitResp(output int at);
    bit got = 0;
    at = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.resp_valid) begin got = 1; at = cyc; end
    end
    check("resp timeout", got, 1);
  endtask

  // One isolated operation with hand-computed expectations
  task automatic runOne(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eR, input logic eC, input logic eO, input logic eZ);
    int acc, at;
    @(posedge clk); #1;
    setReq(i, c, a, b);
    bus.resp_ready = 1'b1;
    waitAccept(i, acc);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
    waitResp(at);
    check("latency", at - acc, 5);
    check("lit id", bus.resp_id, i);
    check("lit result", bus.resp_result, eR);
    check("lit flags", {bus.resp_carryout, bus.resp_overflow, bus.resp_zero}, {eC, eO, eZ});
  endtask

  initial begin
    int order[$];
    int acc, at, g;
    clk = 1'b0; reset = 1'b1;
    bus.req_valid = '0; bus.req_cmd = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst req_ready", bus.req_ready, 0);
    check("rst resp_valid", bus.resp_valid, 0);

    // Basic arithmetic and flag cases
    runOne(0, CMD_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0);
    runOne(1, CMD_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    runOne(1, CMD_SUB, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 1'b1);
    runOne(2, CMD_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    runOne(2, CMD_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);

    // All requesters valid continuously from reset: fair rotation
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < N; i++) setReq(i, 3'(4 + i), 32'hA5A5_0000 + 32'(i), 32'h0F0F_00FF);
    @(posedge clk); #1 reset = 1'b0;
    for (int t = 0; t < 100 && order.size() < 5; t++) begin
      @(negedge clk);
      g = -1;
      for (int k = 0; k < N; k++) if (bus.req_valid[k] && bus.req_ready[k]) g = k;
      if (g >= 0) order.push_back(g);
    end
    check("rr count", order.size(), 5);
    while (order.size() < 5) order.push_back(-1);
    check("rr order0", order[0], 0);
    check("rr order1", order[1], 1);
    check("rr order2", order[2], 2);
    check("rr order3", order[3], 3);
    check("rr order4", order[4], 0);
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (8) @(posedge clk);

    // Response back-pressure: result held, no grants while stalled
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    setReq(3, CMD_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    bus.resp_ready = 1'b0;
    waitAccept(3, acc);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    setReq(1, CMD_NOR, 32'h0000_FFFF, 32'h00FF_0000);
    waitResp(at);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("stall valid", bus.resp_valid, 1);
      check("stall ready", bus.req_ready, 0);
      check("stall result", bus.resp_result, 32'hFF00_FF00);
    end
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release idle", bus.resp_valid, 0);
    check("release grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    repeat (8) @(posedge clk);

    // Reset during settle drops the op and restarts arbitration at 0
    #1 setReq(2, CMD_ADD, 32'd1, 32'd2);
    waitAccept(2, acc);
    @(posedge clk); #1 bus.req_valid[2] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    setReq(1, CMD_AND, 32'hFFFF_0000, 32'h1234_5678);
    setReq(3, CMD_OR, 32'd1, 32'd2);
    @(negedge clk);
    check("post-rst resp_valid", bus.resp_valid, 0);
    check("post-rst alu_a", aluA, 0);
    check("post-rst grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1 bus.req_valid = '0;
    waitResp(at);
    check("post-rst id", bus.resp_id, 1);
    check("post-rst result", bus.resp_result, 32'h1234_0000);
    repeat (6) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
